// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch controller and its pc queue.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Wide enough for occ (up to 8) and outst/drop (up to 4)
  localparam int unsigned FETCH_CNT_W = 4;

  function automatic int unsigned fetch_entry_w(input int unsigned addr_w,
                                                input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/riscv_fifo.sv
// Small circular FIFO with combinational read of the oldest entry.
module riscv_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// Instruction fetch controller: credit-based bus requests, in-order response
// forwarding into the instruction FIFO, and redirect handling with drain.
module riscv_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 3,
  parameter int unsigned       MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  output logic                                      ibus_req,
  output logic [ADDR_W-1:0]                         ibus_addr,
  input  logic                                      ibus_gnt,
  input  logic                                      ibus_rvalid,
  input  logic [DATA_W-1:0]                         ibus_rdata,
  input  logic                                      redirect,
  input  logic [ADDR_W-1:0]                         redirect_pc,
  output logic                                      fifo_push,
  output logic [fetch_entry_w(ADDR_W, DATA_W)-1:0]  fifo_data_in,
  input  logic                                      fifo_pop,
  output logic                                      fifo_flush
);

  localparam int unsigned CNT_W = FETCH_CNT_W;
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] rsp_pc;
  logic              credit_ok;
  logic              grant;
  logic              keep_rsp;

  // Reserve a FIFO slot for every in-flight request so a push never overflows
  assign credit_ok = (({1'b0, occ_q} + {1'b0, outst_q}) < DEPTH_LIM) && (outst_q < OUTST_LIM);
  assign ibus_req  = (state_q == ST_FETCH) && !redirect && credit_ok;
  assign ibus_addr = fetch_pc_q;
  assign grant     = ibus_req && ibus_gnt;
  assign keep_rsp  = ibus_rvalid && (drop_q == '0) && !redirect;

  assign fifo_push    = keep_rsp;
  assign fifo_data_in = {rsp_pc, ibus_rdata};
  assign fifo_flush   = redirect && (state_q != ST_BOOT);

  riscv_fifo #(
    .DEPTH  (MAX_OUTST),
    .DATA_W (ADDR_W)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (grant),
    .data_i  (fetch_pc_q),
    .pop_i   (ibus_rvalid),
    .data_o  (rsp_pc)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    occ_d      = occ_q;
    if (grant) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      outst_d    = outst_d + CNT_W'(1);
    end
    if (ibus_rvalid) outst_d = outst_d - CNT_W'(1);
    if (ibus_rvalid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    if (keep_rsp) occ_d = occ_d + CNT_W'(1);
    if (fifo_pop) occ_d = occ_d - CNT_W'(1);
    // No grant can coincide with redirect, so outst_d already excludes any arriving response
    if (redirect) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      occ_d      = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      occ_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      if (redirect) begin
        state_q <= (drop_d != '0) ? ST_DRAIN : ST_FETCH;
      end else begin
        unique case (state_q)
          ST_BOOT:  state_q <= ST_FETCH;
          ST_FETCH: state_q <= ST_FETCH;
          ST_DRAIN: if (drop_d == '0) state_q <= ST_FETCH;
          default:  state_q <= ST_BOOT;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_pop && (occ_q == '0))) else $error("fifo_pop while FIFO empty");
      assert (!(ibus_rvalid && (outst_q == '0))) else $error("ibus_rvalid with no request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed bench for riscv_fetch_ctrl with default parameters (depth 3, two outstanding).
module tb_riscv_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt = 1'b0;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fifo_push;
  logic [63:0] fifo_data_in;
  logic        fifo_pop = 1'b0;
  logic        fifo_flush;

  int checks = 0;
  int errors = 0;

  riscv_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_req     (ibus_req),
    .ibus_addr    (ibus_addr),
    .ibus_gnt     (ibus_gnt),
    .ibus_rvalid  (ibus_rvalid),
    .ibus_rdata   (ibus_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fifo_push    (fifo_push),
    .fifo_data_in (fifo_data_in),
    .fifo_pop     (fifo_pop),
    .fifo_flush   (fifo_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checking
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdr, input logic [31:0] rpc, input logic pp);
    @(negedge clk);
    ibus_gnt    = g;
    ibus_rvalid = rv;
    ibus_rdata  = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    fifo_pop    = pp;
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {63'd0, ibus_req},   64'd0);
    check("rst_push",  {63'd0, fifo_push},  64'd0);
    check("rst_flush", {63'd0, fifo_flush}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_req", {63'd0, ibus_req}, 64'd0);

    // Fill: three fetches at 0x0/0x4/0x8, response one cycle after grant
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("c1_req",  {63'd0, ibus_req}, 64'd1);
    check("c1_addr", {32'd0, ibus_addr}, 64'h0);
    cyc(1, 1, 32'h0000_0013, 0, 32'h0, 0);
    check("c2_req",  {63'd0, ibus_req}, 64'd1);
    check("c2_addr", {32'd0, ibus_addr}, 64'h4);
    check("c2_push", {63'd0, fifo_push}, 64'd1);
    check("c2_data", fifo_data_in, 64'h0000_0000_0000_0013);
    cyc(1, 1, 32'h0010_0093, 0, 32'h0, 0);
    check("c3_addr", {32'd0, ibus_addr}, 64'h8);
    check("c3_data", fifo_data_in, 64'h0000_0004_0010_0093);
    cyc(1, 1, 32'h0020_0113, 0, 32'h0, 0);
    check("c4_req",  {63'd0, ibus_req}, 64'd0);
    check("c4_data", fifo_data_in, 64'h0000_0008_0020_0113);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("full_req0",  {63'd0, ibus_req},  64'd0);
    check("full_push0", {63'd0, fifo_push}, 64'd0);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("full_req1", {63'd0, ibus_req}, 64'd0);

    // One pop frees exactly one credit
    cyc(1, 0, 32'h0, 0, 32'h0, 1);
    check("pop_req", {63'd0, ibus_req}, 64'd0);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("c8_req",  {63'd0, ibus_req}, 64'd1);
    check("c8_addr", {32'd0, ibus_addr}, 64'hC);
    cyc(1, 1, 32'h0030_0193, 0, 32'h0, 0);
    check("c9_req",  {63'd0, ibus_req}, 64'd0);
    check("c9_data", fifo_data_in, 64'h0000_000C_0030_0193);

    // Empty the FIFO without granting
    cyc(0, 0, 32'h0, 0, 32'h0, 1);
    check("c10_req", {63'd0, ibus_req}, 64'd0);
    cyc(0, 0, 32'h0, 0, 32'h0, 1);
    check("c11_req", {63'd0, ibus_req}, 64'd1);
    cyc(0, 0, 32'h0, 0, 32'h0, 1);

    // Two outstanding at 0x10/0x14, then redirect to 0x103
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("c13_addr", {32'd0, ibus_addr}, 64'h10);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("c14_req",  {63'd0, ibus_req}, 64'd1);
    check("c14_addr", {32'd0, ibus_addr}, 64'h14);
    cyc(1, 0, 32'h0, 1, 32'h0000_0103, 0);
    check("rd_req",   {63'd0, ibus_req},   64'd0);
    check("rd_flush", {63'd0, fifo_flush}, 64'd1);
    cyc(1, 1, 32'hDEAD_0001, 0, 32'h0, 0);
    check("drain1_flush", {63'd0, fifo_flush}, 64'd0);
    check("drain1_req",   {63'd0, ibus_req},   64'd0);
    check("drain1_push",  {63'd0, fifo_push},  64'd0);
    cyc(1, 1, 32'hDEAD_0002, 0, 32'h0, 0);
    check("drain2_req",  {63'd0, ibus_req},  64'd0);
    check("drain2_push", {63'd0, fifo_push}, 64'd0);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("post_drain_req",  {63'd0, ibus_req}, 64'd1);
    check("post_drain_addr", {32'd0, ibus_addr}, 64'h100);

    // Redirect coincident with the last outstanding response
    cyc(0, 1, 32'hBEEF_0000, 1, 32'h0000_0200, 0);
    check("rdrv_push",  {63'd0, fifo_push},  64'd0);
    check("rdrv_flush", {63'd0, fifo_flush}, 64'd1);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("rdrv_next_req",  {63'd0, ibus_req}, 64'd1);
    check("rdrv_next_addr", {32'd0, ibus_addr}, 64'h200);
    cyc(0, 1, 32'h0040_0213, 0, 32'h0, 0);
    check("c21_push", {63'd0, fifo_push}, 64'd1);
    check("c21_data", fifo_data_in, 64'h0000_0200_0040_0213);

    // Grant held low: request and address must stay put
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 32'h0, 0, 32'h0, 0);
      check($sformatf("stall%0d_req", i),  {63'd0, ibus_req},  64'd1);
      check($sformatf("stall%0d_addr", i), {32'd0, ibus_addr}, 64'h204);
      check($sformatf("stall%0d_push", i), {63'd0, fifo_push}, 64'd0);
    end

    // Address wrap at the top of the space, with low-bit masking of redirect_pc
    cyc(0, 0, 32'h0, 1, 32'hFFFF_FFFE, 0);
    check("wrap_flush", {63'd0, fifo_flush}, 64'd1);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("wrap_addr", {32'd0, ibus_addr}, 64'hFFFF_FFFC);
    cyc(0, 1, 32'h0050_0293, 0, 32'h0, 0);
    check("wrap_next_addr", {32'd0, ibus_addr}, 64'h0);
    check("wrap_push",      {63'd0, fifo_push}, 64'd1);
    check("wrap_data",      fifo_data_in, 64'hFFFF_FFFC_0050_0293);

    // Reset with a request in flight returns to BOOT and RESET_PC
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("pre_rst_addr", {32'd0, ibus_addr}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    ibus_gnt = 1'b0;
    #1;
    check("mid_rst_req", {63'd0, ibus_req}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reboot_req", {63'd0, ibus_req}, 64'd0);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    check("reboot_fetch_req",  {63'd0, ibus_req}, 64'd1);
    check("reboot_fetch_addr", {32'd0, ibus_addr}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_ctrl.md
RISCV_FETCH_CTRL -- requirements
Module: riscv_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 3, slot count of the downstream instruction FIFO (range 1..8).
REQ-004 SHALL have parameter MAX_OUTST, default 2, maximum in-flight bus requests (range 1..4).
REQ-005 SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-006 One clock; reset is asynchronous and active-high; ports: clk  input  1  clock; rst  input  1  async active-high reset.
REQ-007 ibus_req  output  1  fetch request valid.
REQ-008 ibus_addr  output  ADDR_W  word-aligned fetch address.
REQ-009 ibus_gnt  input  1  request accepted this cycle.
REQ-010 ibus_rvalid  input  1  response valid, in request order.
REQ-011 ibus_rdata  input  DATA_W  response instruction.
REQ-012 redirect  input  1  branch/exception redirect strobe.
REQ-013 redirect_pc  input  ADDR_W  new fetch address.
REQ-014 fifo_push  output  1  write to instruction FIFO.
REQ-015 fifo_data_in  output  ADDR_W+DATA_W  {pc, instr} entry.
REQ-016 fifo_pop  input  1  consumer pop (same signal driving the FIFO).
REQ-017 fifo_flush  output  1  FIFO flush strobe.

Function
REQ-018 SHALL keep counters outst (requests granted, response pending), drop (pending responses to discard) and occ (FIFO entries), each 0..max, no wrap.
REQ-019 SHALL assert ibus_req only in state FETCH when occ + outst < FIFO_DEPTH and outst < MAX_OUTST, with redirect low; ibus_addr = fetch_pc.
REQ-020 On ibus_req && ibus_gnt, SHALL advance fetch_pc by 4 (modulo 2^ADDR_W) and increment outst; the pc of each granted request SHALL be held in a MAX_OUTST-entry pc queue.
REQ-021 On ibus_rvalid with drop == 0, SHALL assert fifo_push same cycle with fifo_data_in = {oldest queued pc, ibus_rdata}, decrement outst, increment occ (zero latency, combinational push).
REQ-022 On ibus_rvalid with drop > 0, SHALL discard the data, decrement drop and outst, no push.
REQ-023 fifo_pop SHALL decrement occ; simultaneous push and pop SHALL leave occ unchanged; fifo_pop with occ == 0 is illegal (simulation error).
REQ-024 ibus_rvalid with outst == 0 is illegal (simulation error).
REQ-025 FSM states: BOOT, FETCH, DRAIN.
REQ-026 BOOT -> FETCH after one cycle; fetch_pc = RESET_PC.
REQ-027 redirect in any state SHALL: pulse fifo_flush the same cycle, set occ = 0, set drop = outst minus any response arriving and discarded that cycle, load fetch_pc = redirect_pc & ~3, go to DRAIN if resulting drop > 0 else FETCH; a grant in the redirect cycle is impossible (REQ-019).
REQ-028 DRAIN -> FETCH when drop reaches 0; no requests in DRAIN.
REQ-029 redirect in the same cycle as ibus_rvalid SHALL suppress fifo_push.
REQ-030 fifo_push SHALL never be asserted while occ == FIFO_DEPTH (guaranteed by credit rule REQ-019).

Reset
REQ-031 rst SHALL asynchronously set state = BOOT, fetch_pc = RESET_PC, outst = drop = occ = 0, pc queue pointers 0.
REQ-032 During and after reset until first FETCH cycle: ibus_req = 0, fifo_push = 0, fifo_flush = 0.
REQ-033 Reset mid-transfer SHALL abandon in-flight requests; the bus is reset together with the block.

Structure
REQ-034 FSM state encoding and the {pc, instr} entry width constant SHALL live in the shared riscv_pkg package.
REQ-035 The pc queue SHALL be an instance of riscv_fifo (DEPTH = MAX_OUTST, DATA_W = ADDR_W, flush tied 0); no other sub-module.

Verification
REQ-036 Reset release, gnt=1, rvalid one cycle after grant, no pops -> addresses 0x0,0x4,0x8 issued, 3 pushes, then ibus_req stays 0 (FIFO_DEPTH=3).
REQ-037 FIFO full, single fifo_pop -> exactly one new request 0xC issued next cycle.
REQ-038 Two outstanding at 0x10/0x14, redirect to 0x103 -> fifo_flush 1 cycle, both responses discarded, state DRAIN, next request addr 0x100.
REQ-039 redirect coincident with rvalid of last outstanding -> no push, drop = 0, FETCH next cycle with new pc.
REQ-040 gnt held low 10 cycles -> ibus_req and ibus_addr stable, outst = 0, no pushes.
REQ-041 fetch_pc 0xFFFFFFFC granted -> next address 0x0, pushed entry pc = 0xFFFFFFFC.
